// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/MEM external bus arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_IBUS,
        ARB_DBUS,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWNER_I,
        OWNER_D
    } owner_t;

    // Instruction fetches always read a full word.
    localparam logic [3:0] FETCH_SEL = 4'hF;

endpackage

// File: rtl/mem_arb_timer.sv
// Bus watchdog for mem_arbiter: counts stalled bus cycles and flags the last
// permitted one. Instantiated only when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // High during the TIMEOUT-th bus cycle, so bus_req_o stays up exactly TIMEOUT cycles.
    assign expire = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the external memory bus between instruction fetch and the MEM stage,
// one outstanding transaction at a time. Optional watchdog: MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,

    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              mem_ack_o,
    output logic [DATA_W-1:0] mem_rdata_o,

    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,

    output logic              stallreq_if_o,
    output logic              stallreq_mem_o,
    output logic              err_o
);

    arb_state_t state;
    owner_t     owner;
    logic       busy;
    logic       expire;

    assign busy = (state == ARB_IBUS) || (state == ARB_DBUS);

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == ARB_IDLE),
        .inc    (busy && !bus_ack_i),
        .expire (expire)
    );
`else
    // No watchdog: a transaction waits for the slave forever.
    assign expire = (TIMEOUT == 0) && 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            owner       <= OWNER_I;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            if_ack_o    <= 1'b0;
            if_rdata_o  <= '0;
            mem_ack_o   <= 1'b0;
            mem_rdata_o <= '0;
            err_o       <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    // Data wins: it belongs to the older instruction.
                    if (mem_req_i) begin
                        owner       <= OWNER_D;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_sel_o   <= mem_sel_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_wdata_o <= mem_wdata_i;
                        state       <= ARB_DBUS;
                    end else if (if_req_i) begin
                        owner       <= OWNER_I;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_sel_o   <= FETCH_SEL;
                        bus_addr_o  <= if_addr_i;
                        bus_wdata_o <= '0;
                        state       <= ARB_IBUS;
                    end
                end

                ARB_IBUS, ARB_DBUS: begin
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        err_o     <= 1'b0;
                        state     <= ARB_RESP;
                        if (owner == OWNER_I) begin
                            if_rdata_o <= bus_rdata_i;
                            if_ack_o   <= 1'b1;
                        end else begin
                            if (!bus_we_o) begin
                                mem_rdata_o <= bus_rdata_i;
                            end
                            mem_ack_o <= 1'b1;
                        end
                    end else if (expire) begin
                        bus_req_o <= 1'b0;
                        err_o     <= 1'b1;
                        state     <= ARB_RESP;
                        if (owner == OWNER_I) begin
                            if_rdata_o <= '0;
                            if_ack_o   <= 1'b1;
                        end else begin
                            mem_rdata_o <= '0;
                            mem_ack_o   <= 1'b1;
                        end
                    end
                end

                ARB_RESP: begin
                    // No arbitration here, so a still-high request is not reissued.
                    if_ack_o  <= 1'b0;
                    mem_ack_o <= 1'b0;
                    err_o     <= 1'b0;
                    state     <= ARB_IDLE;
                end

                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign stallreq_mem_o = mem_req_i && !((state == ARB_RESP) && (owner == OWNER_D));
    assign stallreq_if_o  = if_req_i  && !((state == ARB_RESP) && (owner == OWNER_I));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: randomized IF/MEM requesters and a bus slave
// model; a separate monitor checks acks, read data, stalls and the bus command.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              mem_req_i;
    logic              mem_we_i;
    logic [3:0]        mem_sel_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              mem_ack_o;
    logic [DATA_W-1:0] mem_rdata_o;
    logic              bus_req_o;
    logic              bus_we_o;
    logic [3:0]        bus_sel_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic              bus_ack_i;
    logic [DATA_W-1:0] bus_rdata_i;
    logic              stallreq_if_o;
    logic              stallreq_mem_o;
    logic              err_o;

    mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_i       (if_req_i),
        .if_addr_i      (if_addr_i),
        .if_ack_o       (if_ack_o),
        .if_rdata_o     (if_rdata_o),
        .mem_req_i      (mem_req_i),
        .mem_we_i       (mem_we_i),
        .mem_sel_i      (mem_sel_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_ack_o      (mem_ack_o),
        .mem_rdata_o    (mem_rdata_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_sel_o      (bus_sel_o),
        .bus_addr_o     (bus_addr_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_ack_i      (bus_ack_i),
        .bus_rdata_i    (bus_rdata_i),
        .stallreq_if_o  (stallreq_if_o),
        .stallreq_mem_o (stallreq_mem_o),
        .err_o          (err_o)
    );

    initial forever #5 clk = ~clk;

    // One expected response per completed bus transaction.
    typedef struct packed {
        logic              owner_d;
        logic              is_read;
        logic              err;
        logic [DATA_W-1:0] data;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    bound_expired = 1'b0;

    function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endfunction

    // ---------------- monitor / reference model ----------------
    bit                mon_prev_idle = 1'b1;
    bit                mon_prev_bus  = 1'b0;
    bit                mon_has;
    bit                mon_exp_bus;
    bit                mon_cur_mem;
    resp_t             mon_e;
    logic [36:0]       mon_cur_cmd;
    logic [DATA_W-1:0] mon_cur_wdata;
    logic [DATA_W-1:0] model_if_rdata  = '0;
    logic [DATA_W-1:0] model_mem_rdata = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("wait_bound", 128'(bound_expired), 128'(1'b0));
            if (rst) begin
                chk("reset_ctrl", 128'({if_ack_o, mem_ack_o, err_o, bus_req_o, bus_we_o, bus_sel_o,
                                        stallreq_if_o, stallreq_mem_o}), 128'(0));
                chk("reset_data", 128'({if_rdata_o, mem_rdata_o, bus_wdata_o}), 128'(0));
                chk("reset_addr", 128'(bus_addr_o), 128'(0));
                model_if_rdata  = '0;
                model_mem_rdata = '0;
                mon_prev_idle   = 1'b1;
                mon_prev_bus    = 1'b0;
            end else begin
                mon_has = (exp_q.size() > 0);
                mon_e   = mon_has ? exp_q.pop_front() : '0;
                if (mon_has) begin
                    if (mon_e.owner_d) begin
                        if (mon_e.err)          model_mem_rdata = '0;
                        else if (mon_e.is_read) model_mem_rdata = mon_e.data;
                    end else begin
                        if (mon_e.err)          model_if_rdata = '0;
                        else if (mon_e.is_read) model_if_rdata = mon_e.data;
                    end
                end
                chk("if_ack",  128'(if_ack_o),  128'(mon_has && !mon_e.owner_d));
                chk("mem_ack", 128'(mem_ack_o), 128'(mon_has && mon_e.owner_d));
                chk("err",     128'(err_o),     128'(mon_has && mon_e.err));
                chk("if_rdata",  128'(if_rdata_o),  128'(model_if_rdata));
                chk("mem_rdata", 128'(mem_rdata_o), 128'(model_mem_rdata));
                chk("stall_if",  128'(stallreq_if_o),
                    128'(if_req_i && !(mon_has && !mon_e.owner_d)));
                chk("stall_mem", 128'(stallreq_mem_o),
                    128'(mem_req_i && !(mon_has && mon_e.owner_d)));

                // Bus is granted from idle the edge after a request is seen, held until the response.
                mon_exp_bus = mon_prev_idle ? (mem_req_i || if_req_i) : (mon_prev_bus && !mon_has);
                chk("bus_req", 128'(bus_req_o), 128'(mon_exp_bus));
                if (mon_exp_bus && !mon_prev_bus) begin
                    mon_cur_mem = mem_req_i;
                    if (mem_req_i) begin
                        mon_cur_cmd   = {mem_we_i, mem_sel_i, mem_addr_i};
                        mon_cur_wdata = mem_wdata_i;
                    end else begin
                        mon_cur_cmd   = {1'b0, 4'hF, if_addr_i};
                        mon_cur_wdata = '0;
                    end
                end
                if (mon_exp_bus) begin
                    chk("bus_cmd", 128'({bus_we_o, bus_sel_o, bus_addr_o}), 128'(mon_cur_cmd));
                    if (mon_cur_mem) chk("bus_wdata", 128'(bus_wdata_o), 128'(mon_cur_wdata));
                end
                mon_prev_idle = !mon_exp_bus && !mon_has;
                mon_prev_bus  = mon_exp_bus;
            end
        end
    end

    // ---------------- driver: requesters and bus slave ----------------
    bit                rand_en       = 1'b0;
    bit                slave_off     = 1'b0;
    bit                slave_mute    = 1'b0;
    bit                force_wait_en = 1'b0;
    int unsigned       force_waits   = 0;
    bit                force_data_en = 1'b0;
    logic [DATA_W-1:0] force_data    = '0;
    bit                in_txn        = 1'b0;
    bit                cur_d;
    bit                cur_read;
    int unsigned       hi_cnt;
    int unsigned       waits;
    bit                mem_drop      = 1'b0;
    bit                if_drop       = 1'b0;

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic slave_step();
        resp_t r;
        if (slave_off) return;
        bus_ack_i = 1'b0;
        if (!bus_req_o) return;
        if (!in_txn) begin
            in_txn   = 1'b1;
            hi_cnt   = 0;
            cur_d    = mem_req_i;
            cur_read = mem_req_i ? !mem_we_i : 1'b1;
            waits    = force_wait_en ? force_waits : $urandom_range(0, 4);
        end
        hi_cnt++;
        if (!slave_mute && hi_cnt > waits) begin
            bus_rdata_i = force_data_en ? force_data : $urandom;
            bus_ack_i   = 1'b1;
            r.owner_d   = cur_d;
            r.is_read   = cur_read;
            r.err       = 1'b0;
            r.data      = bus_rdata_i;
            exp_q.push_back(r);
            in_txn = 1'b0;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (slave_mute && hi_cnt == TIMEOUT) begin
            r.owner_d = cur_d;
            r.is_read = cur_read;
            r.err     = 1'b1;
            r.data    = '0;
            exp_q.push_back(r);
            in_txn = 1'b0;
        end
`endif
    endtask

    // Requests stay up through the ack cycle and drop in the cycle after it.
    task automatic req_step();
        if (mem_req_i) begin
            if (mem_drop) begin
                mem_req_i = 1'b0;
                mem_drop  = 1'b0;
            end else if (mem_ack_o) begin
                mem_drop = 1'b1;
            end
        end else if (rand_en && $urandom_range(0, 2) == 0) begin
            mem_we_i    = 1'($urandom_range(0, 1));
            mem_sel_i   = 4'($urandom_range(1, 15));
            mem_addr_i  = $urandom & ~32'h3;
            mem_wdata_i = $urandom;
            mem_req_i   = 1'b1;
        end
        if (if_req_i) begin
            if (if_drop) begin
                if_req_i = 1'b0;
                if_drop  = 1'b0;
            end else if (if_ack_o) begin
                if_drop = 1'b1;
            end
        end else if (rand_en && $urandom_range(0, 2) == 0) begin
            if_addr_i = $urandom & ~32'h3;
            if_req_i  = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        slave_step();
        req_step();
    endtask

    task automatic wait_quiet();
        int n = 0;
        do begin
            step();
            n++;
        end while ((mem_req_i || if_req_i || in_txn) && n < 300);
        if (mem_req_i || if_req_i || in_txn) begin
            bound_expired = 1'b1;
            repeat (2) @(negedge clk);
            finish_sim();
        end
    endtask

    task automatic issue_mem(input logic we, input logic [3:0] sel,
                             input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        mem_we_i    = we;
        mem_sel_i   = sel;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        mem_req_i   = 1'b1;
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        mem_sel_i   = '0;
        mem_addr_i  = '0;
        mem_wdata_i = '0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single fetch, slave acks in the first bus cycle.
        force_wait_en = 1'b1;
        force_waits   = 0;
        force_data_en = 1'b1;
        force_data    = 32'h2402_0005;
        if_addr_i     = 32'h0000_0100;
        if_req_i      = 1'b1;
        wait_quiet();
        force_data_en = 1'b0;

        // Simultaneous load and fetch: data first.
        force_wait_en = 1'b0;
        issue_mem(1'b0, 4'hF, 32'h8000_0000, '0);
        if_addr_i = 32'h0000_0104;
        if_req_i  = 1'b1;
        wait_quiet();

        // Store with four slave wait cycles.
        force_wait_en = 1'b1;
        force_waits   = 4;
        issue_mem(1'b1, 4'b0011, 32'h0000_0200, 32'hDEAD_BEEF);
        wait_quiet();
        force_wait_en = 1'b0;

        // Randomized traffic.
        rand_en = 1'b1;
        repeat (3000) step();
        rand_en = 1'b0;
        wait_quiet();

        // Reset in DBUS, then a late ack that must be ignored.
        slave_mute = 1'b1;
        issue_mem(1'b0, 4'hF, 32'h0000_0040, '0);
        n = 0;
        do begin
            step();
            n++;
        end while (!in_txn && n < 20);
        if (!in_txn) begin
            bound_expired = 1'b1;
            repeat (2) @(negedge clk);
            finish_sim();
        end
        @(negedge clk);
        slave_off = 1'b1;
        rst       = 1'b1;
        mem_req_i = 1'b0;
        mem_drop  = 1'b0;
        @(negedge clk);
        rst         = 1'b0;
        bus_ack_i   = 1'b1;
        bus_rdata_i = $urandom;
        @(negedge clk);
        bus_ack_i  = 1'b0;
        in_txn     = 1'b0;
        slave_off  = 1'b0;
        slave_mute = 1'b0;
        repeat (4) step();

`ifdef MEM_ARB_TIMEOUT_EN
        // Slave never answers: abort after TIMEOUT bus cycles.
        slave_mute = 1'b1;
        issue_mem(1'b0, 4'hF, 32'h0000_2000, '0);
        wait_quiet();
        slave_mute = 1'b0;
        repeat (2) step();
`endif

        repeat (3) @(negedge clk);
        finish_sim();
    end

endmodule
